// File: rtl/bmc_soft_pipe.sv
// Branch-metric unit: N soft code bits in, 2^N branch metrics out on one bus.
// Latency: two register stages (per-bit distances, then per-codeword sums).
// Backpressure: valid/ready both sides; each stage holds until it can advance, in_ready combinational from out_ready.
module bmc_soft_pipe #(
  parameter int N  = 2,
  parameter int SW = 3,
  parameter int CW = 16,
  localparam int SMAX = (1 << SW) - 1,
  localparam int BW   = $clog2(N * SMAX + 1),
  localparam int NC   = 1 << N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hard_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*SW-1:0]   rx_sym,
  input  logic [N-1:0]      rx_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NC*BW-1:0]  bm,
  output logic [CW-1:0]     sym_cnt
);

  logic              v1;
  logic              v2;
  logic              adv2;
  logic              accept;
  logic              xfer;
  logic              hbit;
  logic [SW-1:0]     d0_n [N];
  logic [SW-1:0]     d1_n [N];
  logic [SW-1:0]     d0_q [N];
  logic [SW-1:0]     d1_q [N];
  logic [BW-1:0]     acc;
  logic [NC*BW-1:0]  bm_n;

  // Handshake: stage 2 frees when drained downstream; stage 1 frees when it moves into stage 2.
  always_comb begin
    adv2     = v1 & (~v2 | out_ready);
    in_ready = ~rst & ~flush & (~v1 | adv2);
    accept   = in_valid & in_ready;
    xfer     = v2 & out_ready;
    out_valid = v2;
  end

  // Per-bit distance to an expected 0 and to an expected 1; erased bits contribute nothing.
  always_comb begin
    hbit = 1'b0;
    for (int i = 0; i < N; i++) begin
      d0_n[i] = '0;
      d1_n[i] = '0;
      if (!rx_mask[i]) begin
        if (hard_mode) begin
          hbit    = rx_sym[i*SW + SW - 1];
          d0_n[i] = SW'(hbit);
          hbit    = ~rx_sym[i*SW + SW - 1];
          d1_n[i] = SW'(hbit);
        end else begin
          // SMAX - s is the bitwise complement for an SW-bit value.
          d0_n[i] = rx_sym[i*SW +: SW];
          d1_n[i] = ~rx_sym[i*SW +: SW];
        end
      end
    end
  end

  // Per-codeword sum: bit i of j picks the expected-1 or expected-0 distance of code bit i.
  always_comb begin
    bm_n = '0;
    acc  = '0;
    for (int j = 0; j < NC; j++) begin
      acc = '0;
      for (int i = 0; i < N; i++) begin
        acc = acc + (j[i] ? BW'(d1_q[i]) : BW'(d0_q[i]));
      end
      bm_n[j*BW +: BW] = acc;
    end
  end

  // Stage 1: capture distances with their valid bit; flush drops the content.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      for (int i = 0; i < N; i++) begin
        d0_q[i] <= '0;
        d1_q[i] <= '0;
      end
    end else if (flush) begin
      v1 <= 1'b0;
    end else if (accept) begin
      v1   <= 1'b1;
      d0_q <= d0_n;
      d1_q <= d1_n;
    end else if (adv2) begin
      v1 <= 1'b0;
    end
  end

  // Stage 2: metric bus, held stable while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0;
      bm <= '0;
    end else if (flush) begin
      v2 <= 1'b0;
    end else if (adv2) begin
      v2 <= 1'b1;
      bm <= bm_n;
    end else if (xfer) begin
      v2 <= 1'b0;
    end
  end

  // Output transfer counter; a transfer coinciding with flush still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_cnt <= '0;
    end else if (xfer) begin
      sym_cnt <= sym_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Bench for bmc_soft_pipe: default instance (N=2, SW=3) plus an N=3, SW=1 instance.
// Stimulus pushes expected metrics into queues; monitors pop and compare on each output transfer.
// Outputs sampled on the falling edge, inputs driven 1 time unit after the rising edge.
module tb_bmc_soft_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        hard_mode;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  rx_sym;
  logic [1:0]  rx_mask;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] bm;
  logic [15:0] sym_cnt;

  logic        flush3;
  logic        hard_mode3;
  logic        in_valid3;
  logic        in_ready3;
  logic [2:0]  rx_sym3;
  logic [2:0]  rx_mask3;
  logic        out_valid3;
  logic        out_ready3;
  logic [15:0] bm3;
  logic [15:0] sym_cnt3;

  logic [15:0] exp_q[$];
  logic [15:0] exp3_q[$];
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  bmc_soft_pipe u_dut (
    .clk(clk), .rst(rst), .flush(flush), .hard_mode(hard_mode),
    .in_valid(in_valid), .in_ready(in_ready), .rx_sym(rx_sym), .rx_mask(rx_mask),
    .out_valid(out_valid), .out_ready(out_ready), .bm(bm), .sym_cnt(sym_cnt)
  );

  bmc_soft_pipe #(.N(3), .SW(1), .CW(16)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush3), .hard_mode(hard_mode3),
    .in_valid(in_valid3), .in_ready(in_ready3), .rx_sym(rx_sym3), .rx_mask(rx_mask3),
    .out_valid(out_valid3), .out_ready(out_ready3), .bm(bm3), .sym_cnt(sym_cnt3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one symbol to the default instance; expected value queued at acceptance.
  task automatic send(input logic [5:0] s, input logic [1:0] m, input logic h,
                      input logic [15:0] e, input bit push);
    int w;
    w = 0;
    rx_sym = s; rx_mask = m; hard_mode = h; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      nvec++; nerr++;
      $display("FAIL send_timeout: in_ready stayed 0, want 1");
    end else if (push) begin
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send3(input logic [2:0] s, input logic h, input logic [15:0] e);
    int w;
    w = 0;
    rx_sym3 = s; rx_mask3 = 3'b000; hard_mode3 = h; in_valid3 = 1'b1;
    @(negedge clk);
    while (!in_ready3 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready3) begin
      nvec++; nerr++;
      $display("FAIL send3_timeout: in_ready stayed 0, want 1");
    end else begin
      exp3_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid3 = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || exp3_q.size() != 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", exp_q.size() + exp3_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Hamming distance of every 3-bit codeword j to rx, packed 2 bits per codeword.
  function automatic logic [15:0] ham3(input logic [2:0] rx);
    logic [15:0] r;
    logic [2:0]  x;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      x = 3'(j) ^ rx;
      r[j*2 +: 2] = {1'b0, x[0]} + {1'b0, x[1]} + {1'b0, x[2]};
    end
    return r;
  endfunction

  // Monitors: every output transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_out: bm=%0h with nothing expected", bm);
      end else begin
        chk("bm", bm, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid3 && out_ready3) begin
      if (exp3_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_out3: bm=%0h with nothing expected", bm3);
      end else begin
        chk("bm3", bm3, exp3_q.pop_front());
      end
    end
  end

  // Stream symbols {s1,s0} in octal with hand-computed metrics {j3,j2,j1,j0}.
  logic [5:0]  st_sym [8] = '{6'o00, 6'o77, 6'o34, 6'o12, 6'o56, 6'o27, 6'o61, 6'o45};
  logic        st_hard[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [15:0] st_exp [8] = '{16'hE770, 16'h077E, 16'h7867, 16'hB863,
                              16'h386B, 16'h5C29, 16'h72C7, 16'h0112};

  initial begin
    rst = 1'b1; flush = 1'b0; hard_mode = 1'b0; in_valid = 1'b0;
    rx_sym = '0; rx_mask = '0; out_ready = 1'b1;
    flush3 = 1'b0; hard_mode3 = 1'b0; in_valid3 = 1'b0;
    rx_sym3 = '0; rx_mask3 = '0; out_ready3 = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_bm", bm, 0);
    chk("rst_sym_cnt", sym_cnt, 0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    // Soft metric and two-edge latency
    send(6'o70, 2'b00, 1'b0, 16'h70E7, 1'b1);
    @(negedge clk);
    chk("latency_edge1_out_valid", out_valid, 0);
    @(negedge clk);
    chk("latency_edge2_out_valid", out_valid, 1);
    @(posedge clk); #1;
    // Hard mode and puncturing
    send(6'o70, 2'b00, 1'b1, 16'h1021, 1'b1);
    send(6'o70, 2'b10, 1'b0, 16'h7070, 1'b1);
    drain();
    chk("sym_cnt_3", sym_cnt, 3);

    // Short reset pulse between edges clears the counter
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("sym_cnt_cleared", sym_cnt, 0);

    // Back-to-back stream with a 3-cycle downstream stall
    fork
      begin
        for (int k = 0; k < 8; k++) send(st_sym[k], 2'b00, st_hard[k], st_exp[k], 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("in_ready_full", in_ready, 0);
          chk("out_valid_stall", out_valid, 1);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("sym_cnt_stream", sym_cnt, 8);

    // Flush with two symbols held in a stalled pipeline
    out_ready = 1'b0;
    send(6'o12, 2'b00, 1'b0, 16'h0000, 1'b0);
    send(6'o34, 2'b00, 1'b0, 16'h0000, 1'b0);
    flush = 1'b1; in_valid = 1'b1; rx_sym = 6'o56;
    @(negedge clk);
    chk("in_ready_flush", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("out_valid_after_flush", out_valid, 0);
    end
    chk("sym_cnt_after_flush", sym_cnt, 8);
    @(posedge clk); #1;

    // Asynchronous reset with two symbols in flight
    out_ready = 1'b0;
    send(6'o34, 2'b00, 1'b0, 16'h0000, 1'b0);
    send(6'o61, 2'b00, 1'b0, 16'h0000, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_bm", bm, 0);
    chk("arst_sym_cnt", sym_cnt, 0);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("out_valid_after_arst", out_valid, 0);
    end
    chk("in_ready_after_arst", in_ready, 1);
    @(posedge clk); #1;

    // N=3, SW=1: every pattern in both modes gives the Hamming distance
    for (int r = 0; r < 8; r++) begin
      for (int h = 0; h < 2; h++) begin
        send3(3'(r), h[0], ham3(3'(r)));
      end
    end
    drain();
    chk("sym_cnt3_sweep", sym_cnt3, 16);
    chk("sym_cnt_idle", sym_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
